aes_add_round_key_stage: RTL and testbench
==========================================

// Module: aes_add_round_key_stage
// PURPOSE
//  Registered AddRoundKey stage, directly downstream of MixColumns in the AES-128 round datapath.
//  XORs each incoming 128-bit state with the current round key, then advances the key schedule.
//  Expands round keys on the fly, one per accepted beat, from a stored cipher key.
//  Carries 11 beats per block (round 0 to NR) over a valid/ready handshake.
// PARAMETERS
//  NR        10   Rounds per block; beats per block = NR+1. Only 10 (AES-128) is supported.
// PORTS
//  clk        in   1    Single clock; all state changes on the rising edge.
//  rst_n      in   1    Asynchronous, active-low reset.
//  key_load   in   1    Pulse: capture key_in as the cipher key (round key 0).
//  key_in     in   128  Cipher key; byte 0 is [127:120].
//  key_ok     out  1    A cipher key has been loaded since reset.
//  in_valid   in   1    in_state is valid.
//  in_ready   out  1    Stage accepts this cycle.
//  in_state   in   128  Round 0: plaintext. Rounds 1..NR-1: MixColumns output. Round NR: ShiftRows output.
//  out_valid  out  1    out_* fields are valid.
//  out_ready  in   1    Downstream accepts.
//  out_state  out  128  in_state ^ round_key[out_round].
//  out_round  out  4    Round index of this beat (0..NR).
//  out_last   out  1    High when out_round == NR (ciphertext beat).
// BEHAVIOUR
//  Reset values:
//   - out_valid=0, out_state=0, out_round=0, out_last=0.
//   - key_ok=0, internal rnd=0, rk=0, key0=0.
//  Registers:
//   - key0: stored cipher key.
//   - rk: current round key.
//   - rnd: 4-bit round counter, 0..NR.
//  Flow control:
//   - in_ready = key_ok & ~key_load & (~out_valid | out_ready).
//   - Accept = in_valid & in_ready. On accept, out_valid <= 1 next cycle; latency is 1 cycle.
//   - out_valid stays 1 and out_* stay stable until out_ready=1.
//   - Full throughput: back-to-back accepts when out_ready is held high.
//   - If out_valid & out_ready and no accept occurs, out_valid <= 0.
//  Key expansion (FIPS-197), per accept:
//   - w = rk words w0..w3.
//   - t = SubWord(RotWord(w3)) ^ {rcon[rnd+1],24'h0}.
//   - Next words: w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
//   - rcon sequence = 01,02,04,08,10,20,40,80,1b,36.
//   - S-box is combinational inside this block (GF(2^8) inverse + affine); 4 instances.
//  Round counter, on each accept:
//   - rnd < NR: rnd <= rnd+1, rk <= next key.
//   - rnd == NR: rnd <= 0, rk <= key0; the next beat starts a new block.
//  key_load (priority over accept in the same cycle):
//   - key0 <= key_in, rk <= key_in, rnd <= 0, key_ok <= 1.
//   - in_ready is 0 that cycle.
//  key_load mid-block:
//   - The partial block is abandoned; the next accept is round 0 of a new block.
//   - A beat already held in the output register is still presented and is not altered.
//  Async reset mid-operation: all registers return to reset values; key must be reloaded.
//  No accept is possible while key_ok=0.
// CONFIGURATION
//  AES_ARK_RKEY_OUT_EN:
//   - Defined: adds output port out_rkey[127:0], registered with out_state.
//     It holds the round key used for that beat; reset value 0.
//   - Undefined: port absent; behaviour otherwise identical.
// TESTING
//  T1: reset, then key_load with key_in = 2b7e151628aed2a6abf7158809cf4f3c; key_ok=1 next cycle.
//      Round-0 input 3243f6a8885a308d313198a2e0370734 -> out_state 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
//  T2: feed all 11 FIPS-197 App. B beats back-to-back with out_ready=1.
//      One output per cycle. Round-1 key a0fafe1788542cb123a339392a6c7605. Round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
//      Beat 11: out_last=1, out_state 3925841d02dc09fbdc118597196a0b32.
//  T3: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and out_* stable; release -> no beat lost or duplicated.
//  T4: run two blocks back-to-back -> second block's round-0 beat uses key0 again (193de3be... repeats).
//  T5: key_load with in_valid=1 at round 4 -> beat not accepted that cycle; next accept has out_round=0 using the new key.
//  T6: assert rst_n=0 mid-block -> out_valid=0 and key_ok=0 immediately; in_ready=0 until the next key_load.

Source files
------------

// File: rtl/aes_add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage with on-the-fly round-key expansion (valid/ready in and out).
// Optional feature macro: AES_ARK_RKEY_OUT_EN adds o_out_rkey, the round key used for each output beat.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_ark_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires
    assign w_x2   = gf_mul(i_byte, i_byte);
    assign w_x3   = gf_mul(w_x2, i_byte);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    assign o_byte = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
                  ^ rotl8(w_inv, 4) ^ 8'h63;
endmodule

module aes_add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_key_load,
    input  logic [127:0] i_key_in,
    output logic         o_key_ok,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_state,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_state,
    output logic [3:0]   o_out_round,
    output logic         o_out_last
`ifdef AES_ARK_RKEY_OUT_EN
   ,output logic [127:0] o_out_rkey
`endif
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LAST_RND  = 4'(NR);

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
    } ark_beat_t;

    logic [127:0] r_key0;
    logic [127:0] r_rk;
    logic [3:0]   r_rnd;
    logic         r_key_ok;
    logic         r_out_valid;
    ark_beat_t    r_out;
`ifdef AES_ARK_RKEY_OUT_EN
    logic [127:0] r_out_rkey;
`endif

    logic                          w_accept;
    logic                          w_in_ready;
    logic [7:0]                    w_rcon;
    logic [NUM_LANES-1:0][7:0]     w_rot;
    logic [NUM_LANES-1:0][7:0]     w_sub;
    logic [31:0]                   w_t;
    logic [31:0]                   w_n0, w_n1, w_n2, w_n3;
    logic [127:0]                  w_rk_next;
    ark_beat_t                     w_beat;

    // key_load blocks acceptance so a beat never pairs with a key being replaced
    assign w_in_ready = r_key_ok & ~i_key_load & (~r_out_valid | i_out_ready);
    assign w_accept   = i_in_valid & w_in_ready;

    // rcon[rnd+1]; only rnd 0..NR-1 ever advance the schedule
    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            aes_ark_sbox u_sbox (
                .i_byte (w_rot[g]),
                .o_byte (w_sub[g])
            );
        end
    endgenerate

    assign w_t       = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0      = r_rk[127:96] ^ w_t;
    assign w_n1      = r_rk[95:64]  ^ w_n0;
    assign w_n2      = r_rk[63:32]  ^ w_n1;
    assign w_n3      = r_rk[31:0]   ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_beat.state = i_in_state ^ r_rk;
    assign w_beat.round = r_rnd;
    assign w_beat.last  = (r_rnd == LAST_RND);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key0   <= '0;
            r_rk     <= '0;
            r_rnd    <= '0;
            r_key_ok <= 1'b0;
        end else if (i_key_load) begin
            r_key0   <= i_key_in;
            r_rk     <= i_key_in;
            r_rnd    <= '0;
            r_key_ok <= 1'b1;
        end else if (w_accept) begin
            if (r_rnd == LAST_RND) begin
                r_rnd <= '0;
                r_rk  <= r_key0;
            end else begin
                r_rnd <= r_rnd + 4'd1;
                r_rk  <= w_rk_next;
            end
        end
    end

    // Output register is independent of key_load: a held beat is presented unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
`ifdef AES_ARK_RKEY_OUT_EN
            r_out_rkey  <= '0;
`endif
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_beat;
`ifdef AES_ARK_RKEY_OUT_EN
            r_out_rkey  <= r_rk;
`endif
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_key_ok    = r_key_ok;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_state = r_out.state;
    assign o_out_round = r_out.round;
    assign o_out_last  = r_out.last;
`ifdef AES_ARK_RKEY_OUT_EN
    assign o_out_rkey  = r_out_rkey;
`endif
endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Scoreboard bench for aes_add_round_key_stage using FIPS-197 key-schedule vectors.
module tb_aes_add_round_key_stage;
    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_key_load;
    logic [127:0] i_key_in;
    logic         o_key_ok;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [127:0] i_in_state;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [127:0] o_out_state;
    logic [3:0]   o_out_round;
    logic         o_out_last;
`ifdef AES_ARK_RKEY_OUT_EN
    logic [127:0] o_out_rkey;
`endif

    always #5 i_clk = ~i_clk;

    aes_add_round_key_stage #(.NR(10)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key_load  (i_key_load),
        .i_key_in    (i_key_in),
        .o_key_ok    (o_key_ok),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_state  (i_in_state),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_state (o_out_state),
        .o_out_round (o_out_round),
        .o_out_last  (o_out_last)
`ifdef AES_ARK_RKEY_OUT_EN
       ,.o_out_rkey  (o_out_rkey)
`endif
    );

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
        logic [127:0] rk;
    } exp_t;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;

    exp_t         q[$];
    exp_t         e;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           m_rnd = 0;
    int           m_sel = 0;
    int           drv_sel = 0;
    logic [127:0] drv_exp = '0;
    logic [127:0] rk_tab [0:1][0:10];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pop on each output transfer, push on each accept; transfers land on the following rising edge
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            q.delete();
            m_rnd = 0;
        end else begin
            if (o_out_valid && i_out_ready) begin
                chk("sb_nonempty", 128'(q.size() > 0), 128'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_state", o_out_state, e.st);
                    chk("out_round", 128'(o_out_round), 128'(e.rnd));
                    chk("out_last", 128'(o_out_last), 128'(e.last));
`ifdef AES_ARK_RKEY_OUT_EN
                    chk("out_rkey", o_out_rkey, e.rk);
`endif
                end
            end
            if (i_key_load) begin
                m_rnd = 0;
                m_sel = drv_sel;
            end else if (i_in_valid && o_in_ready) begin
                q.push_back('{st: drv_exp, rnd: 4'(m_rnd), last: (m_rnd == 10), rk: rk_tab[m_sel][m_rnd]});
                m_rnd = (m_rnd == 10) ? 0 : m_rnd + 1;
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] s, input logic [127:0] ex, output int n);
        bit acc;
        acc = 1'b0;
        n = 0;
        i_in_valid = 1'b1;
        i_in_state = s;
        drv_exp    = ex;
        while (!acc && n < 50) begin
            @(negedge i_clk);
            acc = i_in_valid && o_in_ready;
            n++;
            @(posedge i_clk);
            #1;
        end
        chk("accept", 128'(acc), 128'd1);
    endtask

    task automatic send_rk(input logic [127:0] s, output int n);
        send(s, s ^ rk_tab[m_sel][m_rnd], n);
    endtask

    task automatic idle(input int cycles);
        i_in_valid = 1'b0;
        repeat (cycles) @(posedge i_clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input int sel);
        i_key_load = 1'b1;
        i_key_in   = k;
        drv_sel    = sel;
        @(posedge i_clk);
        #1;
        i_key_load = 1'b0;
        chk("key_ok", 128'(o_key_ok), 128'd1);
    endtask

    // One full block of key A; v selects which round-10 vector ends it
    task automatic run_block(input int v);
        int n;
        send(PT, 128'h193de3bea0f4e22b9ac68d2ae9f84808, n);
        send('0, 128'ha0fafe1788542cb123a339392a6c7605, n);
        chk("b2b_r1", 128'(n), 128'd1);
        for (int r = 2; r <= 9; r++) begin
            send_rk(rnd128(), n);
            chk("b2b", 128'(n), 128'd1);
        end
        if (v == 0) send(128'he9317db5cb322c723d2e895faf090794, 128'h3925841d02dc09fbdc118597196a0b32, n);
        else        send('0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, n);
        chk("b2b_r10", 128'(n), 128'd1);
    endtask

    initial begin
        int n;
        int w;
        logic [127:0] s;
        rk_tab[0][0]  = KEY_A;
        rk_tab[0][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[0][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[0][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[0][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[0][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[0][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[0][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[0][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[0][9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[0][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) rk_tab[1][i] = '0;
        rk_tab[1][0]  = KEY_B;
        rk_tab[1][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

        i_rst_n = 1'b0; i_key_load = 1'b0; i_key_in = '0;
        i_in_valid = 1'b1; i_in_state = '0; i_out_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 128'(o_out_valid), 128'd0);
        chk("rst_out_state", o_out_state, 128'd0);
        chk("rst_out_round", 128'(o_out_round), 128'd0);
        chk("rst_out_last", 128'(o_out_last), 128'd0);
        chk("rst_key_ok", 128'(o_key_ok), 128'd0);
        chk("rst_in_ready", 128'(o_in_ready), 128'd0);
        @(posedge i_clk);
        #1;
        chk("nokey_ready", 128'(o_in_ready), 128'd0);
        i_in_valid = 1'b0;

        // T1/T2: load FIPS key, full block back-to-back
        load_key(KEY_A, 0);
        run_block(0);
        // T4: two blocks back-to-back, key0 reused for the second round 0
        run_block(1);
        idle(3);

        // T3: output stall with a waiting input beat
        i_out_ready = 1'b0;
        send_rk(rnd128(), n);
        s = rnd128();
        i_in_valid = 1'b1;
        i_in_state = s;
        drv_exp    = s ^ rk_tab[m_sel][m_rnd];
        repeat (5) begin
            @(negedge i_clk);
            chk("stall_in_ready", 128'(o_in_ready), 128'd0);
            chk("stall_out_valid", 128'(o_out_valid), 128'd1);
            if (q.size() > 0) begin
                chk("stall_state", o_out_state, q[0].st);
                chk("stall_round", 128'(o_out_round), 128'(q[0].rnd));
            end
        end
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b1;
        send(s, s ^ rk_tab[m_sel][m_rnd], n);

        // T5: key_load colliding with a valid beat at round 4
        while (m_rnd != 4) send_rk(rnd128(), n);
        s = rnd128();
        i_key_load = 1'b1;
        i_key_in   = KEY_B;
        drv_sel    = 1;
        i_in_valid = 1'b1;
        i_in_state = s;
        @(negedge i_clk);
        chk("kl_in_ready", 128'(o_in_ready), 128'd0);
        @(posedge i_clk);
        #1;
        i_key_load = 1'b0;
        send(s, s ^ KEY_B, n);
        send('0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, n);

        // T6: async reset mid-block
        i_rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 128'(o_out_valid), 128'd0);
        chk("t6_key_ok", 128'(o_key_ok), 128'd0);
        chk("t6_in_ready", 128'(o_in_ready), 128'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_in_valid = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            chk("t6_nokey_ready", 128'(o_in_ready), 128'd0);
        end
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        load_key(KEY_A, 0);
        run_block(0);
        i_in_valid = 1'b0;

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(posedge i_clk);
            w++;
        end
        #1;
        chk("drain", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
